mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-ported 4-cycle main memory between the I-cache fill FSM, the D-cache fill FSM and the D-cache write-through store path. Grants exactly one requester at a time, muxes its address/command onto the memory port, and steers returning read-valid pulses only to the granted fill FSM. It tracks reads in flight so a grant is never revoked while memory data for that requester is still pending.

## Interface
- MEM_LAT, 4, memory read latency in cycles; bounds outstanding reads
- AW, 16, address/data width

- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- i_req  in  1  I-fill wants the memory (held for the whole fill)
- i_rd  in  1  I-fill issues a read this cycle
- i_addr  in  AW  I-fill read address
- d_req  in  1  D-fill wants the memory (held for the whole fill)
- d_rd  in  1  D-fill issues a read this cycle
- d_addr  in  AW  D-fill read address
- w_req  in  1  store pending; held until w_gnt
- w_addr  in  AW  store address
- w_data  in  AW  store data
- mem_data_valid  in  1  memory read data valid
- i_gnt / d_gnt / w_gnt  out  1 each  grant, decoded from registered state
- i_data_valid / d_data_valid  out  1 each  mem_data_valid gated to granted fill
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  access is a write
- mem_addr  out  AW  memory address
- mem_wdata  out  AW  memory write data
- busy  out  1  state != IDLE
- err  out  1  sticky protocol-error flag

## Operation
- States: IDLE, GNT_I, GNT_D, GNT_W.
- IDLE: choose among pending requests; without ARB_RR_EN fixed priority W > D > I. No request → stay.
- GNT_I/GNT_D: mem_enable = x_rd, mem_wr = 0, mem_addr = x_addr. Leave to IDLE when x_req = 0 and outstanding count (after this cycle's update) is 0.
- GNT_W: mem_enable = 1, mem_wr = 1, mem_addr = w_addr, mem_wdata = w_data; exactly one cycle, then IDLE.
- Ungranted x_rd is ignored (no memory access). mem_addr/mem_wdata = 0 when no access.
- Outstanding counter, width clog2(MEM_LAT+1): +1 on issued read, −1 on mem_data_valid, both → unchanged.
- err set on: mem_data_valid with count 0 (pulse not forwarded); read issued with count = MEM_LAT and no valid (count saturates). Cleared only by reset.
- i_data_valid = mem_data_valid & GNT_I & count≠0; d_data_valid likewise for GNT_D.

## Timing
- Reset: state IDLE, all grants 0, mem_enable/mem_wr 0, mem_addr/mem_wdata 0, count 0, err 0, busy 0, RR pointer = W.
- Request sampled in IDLE at edge N → grant high from cycle N+1.
- Every grant is followed by at least one IDLE cycle; back-to-back grant gap = 1 cycle.
- Requester drops x_req while reads pending → grant held until last mem_data_valid, IDLE the cycle after.
- Simultaneous i_req/d_req/w_req in IDLE → single grant per priority rule; others wait, never dropped.
- Async reset mid-fill: immediate return to reset values; in-flight memory data after reset raises err.

## Configuration
- ARB_RR_EN defined: rotating priority; the requester granted most recently becomes lowest priority (order W→D→I rotation); pointer updates on each grant.
- Undefined: fixed priority W > D > I; pointer logic absent.

## Structure
- Shared package: state encoding (IDLE, GNT_I, GNT_D, GNT_W), requester IDs, MEM_LAT default, block size in words (8).
- One sub-module: arb_rd_tracker (outstanding counter, saturation and err detection).

## Test plan
- Lone i_req at cycle 0, 8 i_rd pulses, 8 valids 4 cycles later → i_gnt cycles 1..last valid+1, i_data_valid ×8, d_data_valid never.
- i_req, d_req, w_req together → w_gnt 1 cycle, IDLE, then d_gnt full fill, IDLE, then i_gnt (fixed); with ARB_RR_EN repeated contention rotates W, D, I.
- d_req dropped with 3 reads outstanding → d_gnt stays until third valid, IDLE next cycle.
- mem_data_valid injected in IDLE → no data_valid output, err = 1 and stays 1.
- 5th read issued with 4 outstanding → err = 1, count stays 4.
- rst_n low mid-fill → all outputs at reset values same cycle; new i_req after release granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: FSM encoding, requester IDs, defaults.
package mem_arbiter_pkg;

    localparam int unsigned MemLatDefault = 4;
    localparam int unsigned BlockWords    = 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StGntI = 2'd1;
    localparam logic [1:0] StGntD = 2'd2;
    localparam logic [1:0] StGntW = 2'd3;

    typedef enum logic [1:0] {
        ReqI = 2'd1,
        ReqD = 2'd2,
        ReqW = 2'd3
    } req_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle of the arbiter; slave = arbiter side, master = environment.
interface mem_arbiter_if #(
    parameter int unsigned AW = 16
);

    logic          i_req;
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic          d_req;
    logic          d_rd;
    logic [AW-1:0] d_addr;
    logic          w_req;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] w_data;
    logic          mem_data_valid;

    logic          i_gnt;
    logic          d_gnt;
    logic          w_gnt;
    logic          i_data_valid;
    logic          d_data_valid;
    logic          mem_enable;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] mem_wdata;
    logic          busy;
    logic          err;

    modport slave (
        input  i_req, i_rd, i_addr, d_req, d_rd, d_addr, w_req, w_addr, w_data, mem_data_valid,
        output i_gnt, d_gnt, w_gnt, i_data_valid, d_data_valid, mem_enable, mem_wr, mem_addr,
               mem_wdata, busy, err
    );

    modport master (
        output i_req, i_rd, i_addr, d_req, d_rd, d_addr, w_req, w_addr, w_data, mem_data_valid,
        input  i_gnt, d_gnt, w_gnt, i_data_valid, d_data_valid, mem_enable, mem_wr, mem_addr,
               mem_wdata, busy, err
    );

endinterface

// File: rtl/arb_rd_tracker.sv
// Outstanding-read counter for the granted fill; saturates at MEM_LAT and flags protocol errors.
module arb_rd_tracker #(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_issue_i,
    input  logic valid_i,
    output logic cnt_nz_o,
    output logic zero_next_o,
    output logic err_o
);

    localparam int unsigned CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CntMax = CW'(MEM_LAT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          vld_ok;
    logic          full;

    assign cnt_nz_o = (cnt_q != '0);
    assign vld_ok   = valid_i & cnt_nz_o;
    assign full     = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (rd_issue_i && !vld_ok && !full) begin
            cnt_d = cnt_q + CW'(1);
        end else if (vld_ok && !rd_issue_i) begin
            cnt_d = cnt_q - CW'(1);
        end
        // Stray data with nothing pending, or a read beyond the memory pipeline depth.
        err_d = err_q | (valid_i & ~cnt_nz_o) | (rd_issue_i & full & ~valid_i);
    end

    assign zero_next_o = (cnt_d == '0);
    assign err_o       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter for I-fill, D-fill and store path. Define ARB_RR_EN for rotating
// priority; otherwise fixed priority W > D > I.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = MemLatDefault,
    parameter int unsigned AW      = 16
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus_io
);

    logic [1:0]    state_q, state_d;
    req_id_e       pick;
    logic          any_req;
    logic          in_i, in_d, in_w;
    logic          rd_issue;
    logic          cnt_nz, zero_next, err;
    logic          en_sel, wr_sel;
    logic [AW-1:0] addr_sel, wdata_sel;

    assign in_i     = (state_q == StGntI);
    assign in_d     = (state_q == StGntD);
    assign in_w     = (state_q == StGntW);
    assign any_req  = bus_io.i_req | bus_io.d_req | bus_io.w_req;
    assign rd_issue = (in_i & bus_io.i_rd) | (in_d & bus_io.d_rd);

`ifdef ARB_RR_EN
    req_id_e last_q, last_d;

    // The most recently granted requester drops to the bottom of the W->D->I ring.
    always_comb begin
        pick = ReqW;
        case (last_q)
            ReqW:    pick = bus_io.d_req ? ReqD : (bus_io.i_req ? ReqI : ReqW);
            ReqD:    pick = bus_io.i_req ? ReqI : (bus_io.w_req ? ReqW : ReqD);
            default: pick = bus_io.w_req ? ReqW : (bus_io.d_req ? ReqD : ReqI);
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && any_req) begin
            last_d = pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= ReqW;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        pick = bus_io.w_req ? ReqW : (bus_io.d_req ? ReqD : ReqI);
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    case (pick)
                        ReqW:    state_d = StGntW;
                        ReqD:    state_d = StGntD;
                        default: state_d = StGntI;
                    endcase
                end
            end
            // A fill keeps its grant until its own data has drained.
            StGntI:  if (!bus_io.i_req && zero_next) state_d = StIdle;
            StGntD:  if (!bus_io.d_req && zero_next) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    arb_rd_tracker #(
        .MEM_LAT(MEM_LAT)
    ) u_rd_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_issue_i (rd_issue),
        .valid_i    (bus_io.mem_data_valid),
        .cnt_nz_o   (cnt_nz),
        .zero_next_o(zero_next),
        .err_o      (err)
    );

    always_comb begin
        en_sel    = 1'b0;
        wr_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        if (in_i && bus_io.i_rd) begin
            en_sel   = 1'b1;
            addr_sel = bus_io.i_addr;
        end
        if (in_d && bus_io.d_rd) begin
            en_sel   = 1'b1;
            addr_sel = bus_io.d_addr;
        end
        if (in_w) begin
            en_sel    = 1'b1;
            wr_sel    = 1'b1;
            addr_sel  = bus_io.w_addr;
            wdata_sel = bus_io.w_data;
        end
    end

    assign bus_io.mem_enable   = en_sel;
    assign bus_io.mem_wr       = wr_sel;
    assign bus_io.mem_addr     = addr_sel;
    assign bus_io.mem_wdata    = wdata_sel;
    assign bus_io.i_gnt        = in_i;
    assign bus_io.d_gnt        = in_d;
    assign bus_io.w_gnt        = in_w;
    assign bus_io.i_data_valid = bus_io.mem_data_valid & in_i & cnt_nz;
    assign bus_io.d_data_valid = bus_io.mem_data_valid & in_d & cnt_nz;
    assign bus_io.busy         = (state_q != StIdle);
    assign bus_io.err          = err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against
// a per-cycle ownership/outstanding-read model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned MEM_LAT = 4;
    localparam int unsigned AW      = 16;
`ifdef ARB_RR_EN
    localparam bit RrMode = 1'b1;
`else
    localparam bit RrMode = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW)) bus ();

    mem_arbiter #(
        .MEM_LAT(MEM_LAT),
        .AW     (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Memory: read data returns MEM_LAT cycles after the issuing cycle; not reset.
    logic [7:0] vpipe  = '0;
    logic       mute   = 1'b0;
    logic       inject = 1'b0;
    always @(posedge clk) vpipe <= {vpipe[6:0], bus.mem_enable & ~bus.mem_wr};
    assign bus.mem_data_valid = (vpipe[MEM_LAT-1] & ~mute) | inject;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0 = none, 1 = I, 2 = D, 3 = W; ring index 0 = W, 1 = D, 2 = I.
    int m_own  = 0;
    int m_cnt  = 0;
    int m_last = 0;
    bit m_err  = 1'b0;

    function automatic int ord_id(input int idx);
        case (idx)
            0:       return 3;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int pick_idx(input int last_idx, input logic [3:1] pend);
        int start;
        start = RrMode ? last_idx + 1 : 0;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (start + k) % 3;
            if (pend[ord_id(idx)]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  own, cnt, last, idx;
        bit  er, issued, v, v_ok;
        if (!rst_n) begin
            m_own  <= 0;
            m_cnt  <= 0;
            m_last <= 0;
            m_err  <= 1'b0;
        end else begin
            own    = m_own;
            cnt    = m_cnt;
            last   = m_last;
            er     = m_err;
            issued = (own == 1 && bus.i_rd) || (own == 2 && bus.d_rd);
            v      = bus.mem_data_valid;
            v_ok   = v && cnt > 0;
            if (v && cnt == 0) er = 1'b1;
            if (issued && !v && cnt == MEM_LAT) er = 1'b1;
            cnt = cnt + (issued ? 1 : 0) - (v_ok ? 1 : 0);
            if (cnt > MEM_LAT) cnt = MEM_LAT;
            case (own)
                0: begin
                    idx = pick_idx(last, {bus.w_req, bus.d_req, bus.i_req});
                    if (idx >= 0) begin
                        own  = ord_id(idx);
                        last = idx;
                    end
                end
                1:       if (!bus.i_req && cnt == 0) own = 0;
                2:       if (!bus.d_req && cnt == 0) own = 0;
                default: own = 0;
            endcase
            m_own  <= own;
            m_cnt  <= cnt;
            m_last <= last;
            m_err  <= er;
        end
    end

    int cnt_ig  = 0;
    int cnt_idv = 0;
    int cnt_ddv = 0;

    always @(negedge clk) begin
        logic          e_en, e_wr;
        logic [AW-1:0] e_addr, e_wd;
        e_en   = 1'b0;
        e_wr   = 1'b0;
        e_addr = '0;
        e_wd   = '0;
        if (m_own == 1 && bus.i_rd) begin
            e_en   = 1'b1;
            e_addr = bus.i_addr;
        end
        if (m_own == 2 && bus.d_rd) begin
            e_en   = 1'b1;
            e_addr = bus.d_addr;
        end
        if (m_own == 3) begin
            e_en   = 1'b1;
            e_wr   = 1'b1;
            e_addr = bus.w_addr;
            e_wd   = bus.w_data;
        end
        chk1("i_gnt", bus.i_gnt, m_own == 1);
        chk1("d_gnt", bus.d_gnt, m_own == 2);
        chk1("w_gnt", bus.w_gnt, m_own == 3);
        chk1("busy", bus.busy, m_own != 0);
        chk1("err", bus.err, m_err);
        chk1("i_data_valid", bus.i_data_valid, bus.mem_data_valid && m_own == 1 && m_cnt > 0);
        chk1("d_data_valid", bus.d_data_valid, bus.mem_data_valid && m_own == 2 && m_cnt > 0);
        chk1("mem_enable", bus.mem_enable, e_en);
        chk1("mem_wr", bus.mem_wr, e_wr);
        chkw("mem_addr", bus.mem_addr, e_addr);
        chkw("mem_wdata", bus.mem_wdata, e_wd);
        if (bus.i_gnt) cnt_ig <= cnt_ig + 1;
        if (bus.i_data_valid) cnt_idv <= cnt_idv + 1;
        if (bus.d_data_valid) cnt_ddv <= cnt_ddv + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req  = 1'b0;
        bus.i_rd   = 1'b0;
        bus.i_addr = '0;
        bus.d_req  = 1'b0;
        bus.d_rd   = 1'b0;
        bus.d_addr = '0;
        bus.w_req  = 1'b0;
        bus.w_addr = '0;
        bus.w_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string name, input int budget, output int steps);
        steps = 0;
        while (bus.busy && steps < budget) begin
            step();
            steps++;
        end
        n_chk = n_chk + 1;
        if (bus.busy) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: still busy after %0d cycles", name, budget);
        end
    endtask

    // Issues nrd reads for the granted fill, drops the request and waits for the idle cycle.
    task automatic run_fill(input int who, input int nrd);
        int s;
        for (int k = 0; k < nrd; k++) begin
            if (who == 1) begin
                bus.i_rd   = 1'b1;
                bus.i_addr = AW'(16'h1000 + k);
            end else begin
                bus.d_rd   = 1'b1;
                bus.d_addr = AW'(16'h2000 + k);
            end
            step();
        end
        if (who == 1) begin
            bus.i_rd  = 1'b0;
            bus.i_req = 1'b0;
        end else begin
            bus.d_rd  = 1'b0;
            bus.d_req = 1'b0;
        end
        wait_idle("fill_release", 20, s);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, a0, b0, s, t, who;
        int order[$];

        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_i_gnt", bus.i_gnt, 1'b0);
        chk1("rst_w_gnt", bus.w_gnt, 1'b0);
        chk1("rst_mem_enable", bus.mem_enable, 1'b0);
        chkw("rst_mem_addr", bus.mem_addr, '0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Lone I fill: grant cycles 1..12, eight forwarded valids.
        g0 = cnt_ig;
        a0 = cnt_idv;
        b0 = cnt_ddv;
        bus.i_req = 1'b1;
        step();
        chk1("lone_gnt_first", bus.i_gnt, 1'b1);
        for (int k = 0; k < BlockWords; k++) begin
            bus.i_rd   = 1'b1;
            bus.i_addr = AW'(16'h0100 + k);
            step();
        end
        bus.i_rd  = 1'b0;
        bus.i_req = 1'b0;
        wait_idle("lone_idle", 20, s);
        chki("lone_release_cycles", s, 4);
        chki("lone_gnt_cycles", cnt_ig - g0, 12);
        chki("lone_i_valids", cnt_idv - a0, 8);
        chki("lone_d_valids", cnt_ddv - b0, 0);

        // Three-way contention.
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        bus.w_req  = 1'b1;
        bus.w_addr = 16'h0bad;
        bus.w_data = 16'hcafe;
        for (int g = 0; g < 3; g++) begin
            who = 0;
            t   = 0;
            while (who == 0 && t < 10) begin
                step();
                t++;
                who = bus.w_gnt ? 3 : (bus.d_gnt ? 2 : (bus.i_gnt ? 1 : 0));
            end
            chki("contend_wait", t, 1);
            order.push_back(who);
            if (who == 3) begin
                chk1("store_wr", bus.mem_wr, 1'b1);
                chkw("store_addr", bus.mem_addr, 16'h0bad);
                chkw("store_wdata", bus.mem_wdata, 16'hcafe);
                bus.w_req = 1'b0;
                step();
                chk1("store_then_idle", bus.busy, 1'b0);
            end else if (who != 0) begin
                run_fill(who, BlockWords);
            end
        end
        chki("order_0", order[0], 3);
        chki("order_1", order[1], 2);
        chki("order_2", order[2], 1);
        idle_inputs();

        // D fill dropped with three reads outstanding.
        bus.d_req = 1'b1;
        step();
        bus.d_rd = 1'b1;
        repeat (3) step();
        bus.d_rd  = 1'b0;
        bus.d_req = 1'b0;
        chk1("drop_gnt_held", bus.d_gnt, 1'b1);
        repeat (3) step();
        chk1("drop_gnt_last_valid", bus.d_gnt, 1'b1);
        chk1("drop_last_dvalid", bus.d_data_valid, 1'b1);
        step();
        chk1("drop_gnt_released", bus.d_gnt, 1'b0);
        chk1("drop_idle", bus.busy, 1'b0);

        // Stray data valid while idle.
        inject = 1'b1;
        #1;
        chk1("stray_no_ivalid", bus.i_data_valid, 1'b0);
        chk1("stray_no_dvalid", bus.d_data_valid, 1'b0);
        step();
        inject = 1'b0;
        chk1("stray_err", bus.err, 1'b1);
        repeat (3) step();
        chk1("stray_err_sticky", bus.err, 1'b1);

        // Fifth read with four outstanding: error, count holds at four.
        do_reset();
        mute      = 1'b1;
        bus.i_req = 1'b1;
        step();
        bus.i_rd = 1'b1;
        repeat (5) step();
        bus.i_rd  = 1'b0;
        bus.i_req = 1'b0;
        chk1("sat_err", bus.err, 1'b1);
        for (int k = 0; k < 4; k++) begin
            inject = 1'b1;
            #1;
            chk1("sat_gnt_drain", bus.i_gnt, 1'b1);
            chk1("sat_ivalid", bus.i_data_valid, 1'b1);
            step();
        end
        inject = 1'b0;
        chk1("sat_released", bus.i_gnt, 1'b0);
        repeat (6) step();
        mute = 1'b0;

        // Asynchronous reset in the middle of a fill.
        do_reset();
        bus.i_req = 1'b1;
        step();
        bus.i_rd = 1'b1;
        repeat (3) step();
        bus.i_rd = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk1("arst_i_gnt", bus.i_gnt, 1'b0);
        chk1("arst_mem_enable", bus.mem_enable, 1'b0);
        chkw("arst_mem_addr", bus.mem_addr, '0);
        chk1("arst_busy", bus.busy, 1'b0);
        chk1("arst_err", bus.err, 1'b0);
        bus.i_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk1("arst_stale_no_ivalid", bus.i_data_valid, 1'b0);
        repeat (2) step();
        chk1("arst_stale_err", bus.err, 1'b1);
        bus.i_req = 1'b1;
        step();
        chk1("arst_regrant", bus.i_gnt, 1'b1);
        run_fill(1, 1);

        // Randomized traffic checked by the per-cycle model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (bus.w_gnt) begin
                bus.w_req = 1'b0;
            end else if (!bus.w_req && $urandom_range(0, 9) == 0) begin
                bus.w_req  = 1'b1;
                bus.w_addr = AW'($urandom);
                bus.w_data = AW'($urandom);
            end
            if (bus.i_req) begin
                if ($urandom_range(0, 15) == 0) bus.i_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.i_req = 1'b1;
            end
            if (bus.d_req) begin
                if ($urandom_range(0, 15) == 0) bus.d_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.d_req = 1'b1;
            end
            bus.i_rd   = bus.i_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            bus.d_rd   = bus.d_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            bus.i_addr = AW'($urandom);
            bus.d_addr = AW'($urandom);
            step();
        end
        idle_inputs();
        wait_idle("final_idle", 40, s);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
